spi_word_bridge: RTL

- SPI mode-0 slave that converts serial pins to 16-bit word transfers for the matrix accelerator controller. It sits between the MCU SPI pins and the controller's command/data bus.
- Receive path: MOSI is deserialized and each word is presented to the controller's spi-to-bus port as one valid pulse.
- Transmit path: result words from the controller's bus-to-spi port are double-buffered and serialized onto MISO.

---
 rtl/spi_bridge_pkg.sv | 18 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_word_bridge.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI word bridge and the matrix accelerator controller.
// Opcodes live here so the controller and benches decode the same values.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    localparam logic [15:0] IDLE_WORD_DEFAULT = 16'h0000;

    localparam logic [3:0] START_CAL   = 4'h3;
    localparam logic [3:0] WRITE_VEC   = 4'h4;
    localparam logic [3:0] WRITE_MAT   = 4'h5;
    localparam logic [3:0] READ_RESULT = 4'h6;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with one-clk rise/fall pulses
// derived from an extra edge-detect flop behind the synchronized level.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_word_bridge.sv
// SPI mode-0 slave: deserializes MOSI into WORD_SIZE-bit words and serializes a
// double-buffered transmit word stream onto MISO, all in the clk domain.
module spi_word_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [WORD_SIZE-1:0] IDLE_WORD   = WORD_SIZE'(IDLE_WORD_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic [WORD_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    input  logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 frame_err,
    output logic                 underrun
);

    localparam int                 CNT_W      = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(WORD_SIZE - 1);
    localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_mosi),
        .level (mosi_level),
        .rise  (),
        .fall  ()
    );

    state_t                 state_reg, state_next;
    logic [FLUSH_W-1:0]     flush_cnt_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [WORD_SIZE-2:0]   rx_shift_reg;
    logic [WORD_SIZE-1:0]   rx_data_reg;
    logic                   rx_valid_reg;
    logic [WORD_SIZE-1:0]   tx_shift_reg;
    logic [WORD_SIZE-1:0]   hold_reg;
    logic                   hold_full_reg;
    logic                   miso_oe_reg;
    logic                   frame_err_reg;
    logic                   underrun_reg;

    logic flushed;
    logic start_evt, end_evt, bit_rise, bit_fall;
    logic reload, shift_out, rx_done;

    // The cs_n synchronizer resets to "deselected", so its level is only trusted
    // once the reset value has been flushed out by real pin samples.
    assign flushed = (flush_cnt_reg == FLUSH_DONE);

    always_comb begin
        state_next = state_reg;
        start_evt  = 1'b0;
        end_evt    = 1'b0;
        bit_rise   = 1'b0;
        bit_fall   = 1'b0;
        unique case (state_reg)
            WAIT_IDLE: begin
                if (flushed && cs_level) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    start_evt  = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    end_evt    = 1'b1;
                end else begin
                    bit_rise = sclk_rise;
                    bit_fall = sclk_fall;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    assign reload    = start_evt | (bit_fall & (bit_cnt_reg == '0));
    assign shift_out = bit_fall & (bit_cnt_reg != '0);
    assign rx_done   = bit_rise & (bit_cnt_reg == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= WAIT_IDLE;
            flush_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            tx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            miso_oe_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            underrun_reg  <= 1'b0;
            miso_oe_reg   <= (state_next == SHIFT);

            if (!flushed) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end

            if (start_evt) begin
                bit_cnt_reg <= '0;
            end

            if (bit_rise) begin
                rx_shift_reg <= {rx_shift_reg[WORD_SIZE-3:0], mosi_level};
                bit_cnt_reg  <= rx_done ? '0 : bit_cnt_reg + 1'b1;
            end

            if (rx_done) begin
                rx_data_reg  <= {rx_shift_reg, mosi_level};
                rx_valid_reg <= 1'b1;
            end

            // Reload priority: held word, then a same-cycle bypass, then the idle filler.
            if (reload) begin
                if (hold_full_reg) begin
                    tx_shift_reg  <= hold_reg;
                    hold_full_reg <= 1'b0;
                end else if (tx_valid) begin
                    tx_shift_reg <= tx_data;
                end else begin
                    tx_shift_reg <= IDLE_WORD;
                    underrun_reg <= 1'b1;
                end
            end else begin
                if (shift_out) begin
                    tx_shift_reg <= {tx_shift_reg[WORD_SIZE-2:0], 1'b0};
                end
                if (tx_valid && !hold_full_reg) begin
                    hold_reg      <= tx_data;
                    hold_full_reg <= 1'b1;
                end
            end

            // End of frame drops any partial word in either direction; the holding buffer survives.
            if (end_evt) begin
                bit_cnt_reg  <= '0;
                rx_shift_reg <= '0;
                tx_shift_reg <= '0;
                if (bit_cnt_reg != '0) begin
                    frame_err_reg <= 1'b1;
                end
            end
        end
    end

    assign spi_miso    = tx_shift_reg[WORD_SIZE-1];
    assign spi_miso_oe = miso_oe_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_ready    = ~hold_full_reg;
    assign frame_err   = frame_err_reg;
    assign underrun    = underrun_reg;

endmodule
